// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation issuer: default widths, the
// INP_VALID beat encodings, ALU command codes, the FSM state type and the
// packed request that travels through the request FIFO.
package alu_pkg;

    localparam int DW_DEF      = 8;
    localparam int CW_DEF      = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int GAPW        = 5;

    // INP_VALID encodings: which operands the ALU should sample this cycle.
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_BOTH = 2'b11;

    // Arithmetic (MODE=1) command codes.
    localparam logic [CW_DEF-1:0] CMD_ADD     = 4'd0;
    localparam logic [CW_DEF-1:0] CMD_SUB     = 4'd1;
    localparam logic [CW_DEF-1:0] CMD_ADD_CIN = 4'd2;
    localparam logic [CW_DEF-1:0] CMD_SUB_CIN = 4'd3;
    localparam logic [CW_DEF-1:0] CMD_INC_A   = 4'd4;
    localparam logic [CW_DEF-1:0] CMD_DEC_A   = 4'd5;
    localparam logic [CW_DEF-1:0] CMD_INC_B   = 4'd6;
    localparam logic [CW_DEF-1:0] CMD_DEC_B   = 4'd7;
    localparam logic [CW_DEF-1:0] CMD_CMP     = 4'd8;
    // Multi-step arithmetic ops: the ALU needs one extra cycle for these.
    localparam logic [CW_DEF-1:0] CMD_MUL_INC = 4'd9;
    localparam logic [CW_DEF-1:0] CMD_MUL_SHL = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOTH,
        S_A,
        S_GAP,
        S_B,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic              mode;
        logic [CW_DEF-1:0] cmd;
        logic [DW_DEF-1:0] opa;
        logic [DW_DEF-1:0] opb;
        logic              cin;
        logic              split;
        logic [GAPW-1:0]   gap;
    } req_t;

    // True for operations whose result appears one cycle later than usual.
    function automatic logic isMultiStep(input logic mode, input logic [CW_DEF-1:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Small synchronous FIFO of packed requests. Read data is available
// combinationally at the head (first-word fall-through). Pointers carry one
// extra wrap bit so full and empty can be told apart.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic push_i,
    input  req_t pushData_i,
    output logic full_o,
    input  logic pop_i,
    output req_t popData_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    req_t        mem_q [DEPTH];
    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;
    logic        doPush;
    logic        doPop;

    assign empty_o    = (wrPtr_q == rdPtr_q);
    assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush     = push_i && !full_o;
    assign doPop      = pop_i && !empty_o;
    assign popData_o  = mem_q[rdPtr_q[AW-1:0]];

    // Storage array; written only on an accepted push, never reset.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
        end
    end

    // Read and write pointers; reset empties the FIFO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues buffered operation requests to the ALU as either one both-operand
// beat or an A beat and a B beat separated by a programmable gap, then pulses
// res_strobe in the cycle the ALU result is valid.
// Optional build macro ALU_ISSUER_STATS_EN adds saturating op_count and
// late_count outputs.
// The request struct uses the package widths, so DW/CW must stay at their
// package defaults.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int CW      = CW_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_mode,
    input  logic [CW-1:0]   req_cmd,
    input  logic [DW-1:0]   req_opa,
    input  logic [DW-1:0]   req_opb,
    input  logic            req_cin,
    input  logic            req_split,
    input  logic [GAPW-1:0] req_gap,
    output logic [1:0]      INP_VALID,
    output logic [DW-1:0]   OPA,
    output logic [DW-1:0]   OPB,
    output logic [CW-1:0]   CMD,
    output logic            MODE,
    output logic            CIN,
    output logic            CE,
    output logic            res_strobe,
    output logic            late_flag,
    output logic            busy
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]     op_count,
    output logic [15:0]     late_count
`endif
);

    localparam logic [GAPW:0] TIMEOUT_CMP = (GAPW + 1)'(TIMEOUT);

    state_t          state_q;
    req_t            hold_q;
    logic [GAPW-1:0] cnt_q;
    logic [1:0]      inpValid_q;
    logic [DW-1:0]   opa_q;
    logic [DW-1:0]   opb_q;
    logic [CW-1:0]   cmd_q;
    logic            mode_q;
    logic            cin_q;
    logic            ce_q;
    logic            resStrobe_q;
    logic            lateFlag_q;

    req_t            pushEntry;
    req_t            popEntry;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            fifoPop;
    logic [GAPW-1:0] latencyM1;
    logic            isLate;

    assign pushEntry = '{mode: req_mode, cmd: req_cmd, opa: req_opa, opb: req_opb,
                         cin: req_cin, split: req_split, gap: req_gap};
    assign req_ready = !fifoFull;
    assign fifoPop   = (state_q == S_IDLE) && !fifoEmpty;
    assign latencyM1 = isMultiStep(hold_q.mode, hold_q.cmd) ? 5'd2 : 5'd1;
    assign isLate    = hold_q.split && ({1'b0, hold_q.gap} >= TIMEOUT_CMP);

    alu_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push_i     (req_valid),
        .pushData_i (pushEntry),
        .full_o     (fifoFull),
        .pop_i      (fifoPop),
        .popData_o  (popEntry),
        .empty_o    (fifoEmpty)
    );

    // Issue FSM; every ALU-facing output is registered on the transition into the state that shows it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            inpValid_q  <= IV_NONE;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b1;
            resStrobe_q <= 1'b0;
            lateFlag_q  <= 1'b0;
        end else begin
            ce_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    inpValid_q  <= IV_NONE;
                    resStrobe_q <= 1'b0;
                    lateFlag_q  <= 1'b0;
                    if (!fifoEmpty) begin
                        hold_q <= popEntry;
                        cmd_q  <= popEntry.cmd;
                        mode_q <= popEntry.mode;
                        cin_q  <= popEntry.cin;
                        opa_q  <= popEntry.opa;
                        if (popEntry.split) begin
                            state_q    <= S_A;
                            inpValid_q <= IV_A;
                        end else begin
                            state_q    <= S_BOTH;
                            inpValid_q <= IV_BOTH;
                            opb_q      <= popEntry.opb;
                        end
                    end
                end
                S_BOTH, S_B: begin
                    inpValid_q <= IV_NONE;
                    cnt_q      <= latencyM1;
                    state_q    <= S_WAIT;
                end
                S_A: begin
                    if (hold_q.gap == '0) begin
                        state_q    <= S_B;
                        inpValid_q <= IV_B;
                        opb_q      <= hold_q.opb;
                    end else begin
                        state_q    <= S_GAP;
                        inpValid_q <= IV_NONE;
                        cnt_q      <= hold_q.gap;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 5'd1) begin
                        state_q    <= S_B;
                        inpValid_q <= IV_B;
                        opb_q      <= hold_q.opb;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_WAIT: begin
                    if (resStrobe_q) begin
                        resStrobe_q <= 1'b0;
                        lateFlag_q  <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (cnt_q == 5'd1) begin
                        resStrobe_q <= 1'b1;
                        lateFlag_q  <= isLate;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign INP_VALID  = inpValid_q;
    assign OPA        = opa_q;
    assign OPB        = opb_q;
    assign CMD        = cmd_q;
    assign MODE       = mode_q;
    assign CIN        = cin_q;
    assign CE         = ce_q;
    assign res_strobe = resStrobe_q;
    assign late_flag  = lateFlag_q;
    assign busy       = (state_q != S_IDLE);

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] opCount_q;
    logic [15:0] lateCount_q;

    // Saturating statistics counters, bumped once per result strobe and per late result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            opCount_q   <= '0;
            lateCount_q <= '0;
        end else begin
            if (resStrobe_q && (opCount_q != 16'hFFFF)) begin
                opCount_q <= opCount_q + 16'd1;
            end
            if (lateFlag_q && (lateCount_q != 16'hFFFF)) begin
                lateCount_q <= lateCount_q + 16'd1;
            end
        end
    end

    assign op_count   = opCount_q;
    assign late_count = lateCount_q;
`endif

endmodule
